tv_recorder: RTL



---
 rtl/tv_pkg.sv | 15 +
 rtl/tv_mem.sv | 27 ++
 rtl/tv_recorder.sv | 118 +++++++++++
 3 files changed

// File: rtl/tv_pkg.sv
// Shared definitions for the test-vector recorder: FSM state encoding and
// default geometry of the capture buffer.
package tv_pkg;

  localparam int DEF_VEC_W  = 3;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/tv_mem.sv
// Vector buffer: DEPTH x VEC_W register array with one synchronous write
// port and one combinational read port. Contents survive reset.
module tv_mem #(
  parameter int VEC_W  = 3,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [VEC_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [VEC_W-1:0]  rdata
);

  logic [VEC_W-1:0] mem [DEPTH];

  // Store the captured vector on the same edge it is presented.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tv_recorder.sv
// Test-vector capture engine: records {inputs, output} vectors into a buffer,
// then streams them out over valid/ready in .tv line order.
module tv_recorder
  import tv_pkg::*;
#(
  parameter int VEC_W  = DEF_VEC_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [VEC_W-1:0]  i_vec,
  input  logic              i_vec_valid,
  output logic              o_busy,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count,
  output logic [VEC_W-1:0]  o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic              o_rd_last,
  output logic              o_done
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ZERO  = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_TWO   = (ADDR_W+1)'(2);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   new_count;
  logic              wr_en;
  logic [VEC_W-1:0]  rd_word;

  // A write can only happen while capturing and while there is room left.
  assign wr_en     = (state == CAPTURE) && i_vec_valid && (o_count < DEPTH_CNT);
  assign new_count = o_count + {{ADDR_W{1'b0}}, wr_en};
  assign o_busy    = (state != IDLE);
  assign o_rd_data = o_rd_valid ? rd_word : {VEC_W{1'b0}};

  tv_mem #(
    .VEC_W  (VEC_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (i_vec),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  // Capture/drain FSM with pointers and registered handshake flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= {ADDR_W{1'b0}};
      rd_ptr     <= {ADDR_W{1'b0}};
      o_count    <= CNT_ZERO;
      o_full     <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_last  <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state   <= CAPTURE;
            wr_ptr  <= {ADDR_W{1'b0}};
            o_count <= CNT_ZERO;
            o_full  <= 1'b0;
          end
        end
        CAPTURE: begin
          if (wr_en) begin
            wr_ptr  <= wr_ptr + PTR_ONE;
            o_count <= new_count;
          end
          // A vector presented alongside i_stop is already folded into new_count.
          if ((new_count == DEPTH_CNT) || (i_stop && (new_count != CNT_ZERO))) begin
            state      <= DRAIN;
            rd_ptr     <= {ADDR_W{1'b0}};
            o_rd_valid <= 1'b1;
            o_rd_last  <= (new_count == CNT_ONE);
            o_full     <= (new_count == DEPTH_CNT);
          end else if (i_stop) begin
            state  <= IDLE;
            o_done <= 1'b1;
          end
        end
        DRAIN: begin
          if (o_rd_valid && i_rd_ready) begin
            if (o_rd_last) begin
              state      <= IDLE;
              o_rd_valid <= 1'b0;
              o_rd_last  <= 1'b0;
              o_full     <= 1'b0;
              o_done     <= 1'b1;
            end else begin
              rd_ptr    <= rd_ptr + PTR_ONE;
              o_rd_last <= (({1'b0, rd_ptr} + CNT_TWO) == o_count);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
